// File: rtl/csa64_mpadd_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS-wide operands through one shared
// W-bit external adder, least-significant word first, chaining the carry between words.
module csa64_mpadd_seq #(
  parameter int W     = 64,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [W*WORDS-1:0] a_in,
  input  logic [W*WORDS-1:0] b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [W*WORDS-1:0] result,
  output logic               c_out,
  output logic [W-1:0]       adder_a,
  output logic [W-1:0]       adder_b,
  output logic               adder_cin,
  input  logic [W-1:0]       adder_sum,
  input  logic               adder_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [W*WORDS-1:0] op_a_reg, op_b_reg;
  logic               sub_reg;
  logic               carry_reg;
  logic               c_out_reg;
  logic [IW-1:0]      idx_reg;
  logic               accept;
  logic               last_word;
  logic [W-1:0]       word_a, word_b;

  assign last_word = (idx_reg == LAST_IDX);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_word) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);

  // Operands are captured once so the requester may change a_in/b_in while we run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg <= '0;
      op_b_reg <= '0;
      sub_reg  <= 1'b0;
    end else if (accept) begin
      op_a_reg <= a_in;
      op_b_reg <= b_in;
      sub_reg  <= sub;
    end
  end

  // Subtraction is a + ~b + 1: the +1 enters as the carry into word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (accept) begin
      idx_reg   <= '0;
      carry_reg <= sub;
    end else if (busy) begin
      idx_reg   <= idx_reg + 1'b1;
      carry_reg <= adder_cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   c_out_reg <= 1'b0;
    else if (busy && last_word) c_out_reg <= adder_cout;
  end

  assign c_out = c_out_reg;

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_reg == IW'(i)) begin
        word_a = op_a_reg[i*W +: W];
        word_b = op_b_reg[i*W +: W];
      end
    end
  end

  // Adder inputs are quiet outside RUN so the shared adder sees no spurious activity.
  assign adder_a   = busy ? word_a : '0;
  assign adder_b   = busy ? (sub_reg ? ~word_b : word_b) : '0;
  assign adder_cin = busy & carry_reg;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_res
      logic [W-1:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word_reg <= '0;
        else if (busy && (idx_reg == IW'(gi)))
          word_reg <= adder_sum;
      end

      assign result[gi*W +: W] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_csa64_mpadd_seq.sv
// Self-checking bench for csa64_mpadd_seq: a behavioural adder feeds the DUT, and results
// are compared with whole-operand arithmetic on 257-bit values.
module tb_csa64_mpadd_seq;

  localparam int W     = 64;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [N-1:0] a_in, b_in;
  logic         ready, busy, done;
  logic [N-1:0] result;
  logic         c_out;
  logic [W-1:0] adder_a, adder_b, adder_sum;
  logic         adder_cin, adder_cout;

  int checks = 0;
  int errors = 0;
  int op_num = 0;

  always #5 clk = ~clk;

  // External combinational 64-bit adder with carry-in.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_cin};

  csa64_mpadd_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .c_out     (c_out),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_sum (adder_sum),
    .adder_cout(adder_cout)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic s);
    logic [N:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  function automatic logic [N-1:0] rand_operand();
    logic [N-1:0] v;
    int mode;
    mode = $urandom_range(0, 7);
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    if (mode == 0) v = '0;
    else if (mode == 1) v = '1;
    else if (mode == 2) v[N-1:W] = '1;
    return v;
  endfunction

  // Entered at #1 after a rising edge with the DUT in IDLE; leaves the same way.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input string name);
    logic [N:0] exp;
    int lat;
    exp = model(a, b, s);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = rand_operand();
    b_in  = rand_operand();
    sub   = $urandom_range(0, 1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (adder_a !== a[W-1:0] || adder_b !== (s ? ~b[W-1:0] : b[W-1:0]) ||
            adder_cin !== s) begin
          errors++;
          $display("FAIL %s first_word: got a=%h b=%h cin=%b, need a=%h b=%h cin=%b", name,
                   adder_a, adder_b, adder_cin, a[W-1:0], s ? ~b[W-1:0] : b[W-1:0], s);
        end
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != WORDS + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d, need %0d", name, lat, WORDS + 1);
    end
    checks++;
    if (result !== exp[N-1:0] || c_out !== exp[N]) begin
      errors++;
      $display("FAIL %s result: got c=%b r=%h, need c=%b r=%h", name, c_out, result,
               exp[N], exp[N-1:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || adder_a !== '0 ||
        result !== exp[N-1:0]) begin
      errors++;
      $display("FAIL %s after_done: got done=%b ready=%b busy=%b adder_a=%h", name, done,
               ready, busy, adder_a);
    end
    op_num++;
    $display("op %0d %s sub=%b c_out=%b result=%h", op_num, name, s, c_out, result);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a_in = '1;
    b_in = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || c_out !== 1'b0 ||
        adder_a !== '0 || adder_b !== '0 || adder_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b busy=%b done=%b c_out=%b result=%h, need 1 0 0 0 0",
               ready, busy, done, c_out, result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("reset released");
  endtask

  task automatic test_directed();
    logic [N-1:0] one;
    logic [N-1:0] w0;
    one = '0;
    one[0] = 1'b1;
    w0 = '0;
    w0[W-1:0] = '1;
    do_op('1, one, 1'b0, "allones_plus_one");
    checks++;
    if (result !== '0 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL wrap_const: got c=%b r=%h, need c=1 r=0", c_out, result);
    end
    do_op('0, one, 1'b1, "zero_minus_one");
    checks++;
    if (result !== '1 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL borrow_const: got c=%b r=%h, need c=0 r=all ones", c_out, result);
    end
    do_op(w0, one, 1'b0, "carry_chain");
    checks++;
    if (result[W +: W] !== 64'd1 || result[W-1:0] !== '0 || result[N-1:2*W] !== '0 ||
        c_out !== 1'b0) begin
      errors++;
      $display("FAIL carry_chain_const: got c=%b r=%h, need c=0 word1=1 others 0", c_out, result);
    end
    do_op(w0, w0, 1'b1, "equal_sub");
  endtask

  task automatic test_start_while_busy();
    logic [N-1:0] a, b;
    logic s;
    logic [N:0] exp;
    int dones;
    a = rand_operand();
    b = rand_operand();
    s = $urandom_range(0, 1);
    exp = model(a, b, s);
    a_in = a;
    b_in = b;
    sub = s;
    start = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int k = 1; k <= WORDS + 1; k++) begin
      #1;
      a_in = rand_operand();
      b_in = rand_operand();
      sub  = ~sub;
      @(negedge clk);
      if (done === 1'b1) dones++;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_start_dones: got %0d done pulses, need 1", dones);
    end
    checks++;
    if (result !== exp[N-1:0] || c_out !== exp[N] || ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_result: got c=%b r=%h ready=%b, need c=%b r=%h ready=1", c_out,
               result, ready, exp[N], exp[N-1:0]);
    end
    op_num++;
    $display("op %0d busy_start sub=%b c_out=%b result=%h", op_num, s, c_out, result);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int dones;
    a_in = rand_operand();
    b_in = rand_operand();
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || c_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: got ready=%b busy=%b done=%b c=%b r=%h, need 1 0 0 0 0",
               ready, busy, done, c_out, result);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || result !== '0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses r=%h, need 0 pulses r=0", dones, result);
    end
    $display("reset mid-run aborted op");
    @(posedge clk);
    #1;
    do_op(rand_operand(), rand_operand(), $urandom_range(0, 1), "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1000; i++)
      do_op(rand_operand(), rand_operand(), $urandom_range(0, 1), "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
